multicycle_control: RTL and testbench

//  Main control FSM for the multicycle RV32 core. Sequences each instruction through

---
 rtl/multicycle_control.sv | 164 ++++++++++++++++
 tb/tb_multicycle_control.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32 core (lw, sw, R-type, beq, jal).
// Latency: Moore outputs from the state register. pcwrite and irwrite also follow zero/mem_ready combinationally.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold their state until mem_ready (when MEM_WAIT=1).
//
// Ports:
//   clk, rst        core clock (rising edge), asynchronous active-high reset
//   opcode          instr[6:0] from the instruction register
//   zero            ALU zero flag, used for beq
//   mem_ready       unified memory finished the current access this cycle
//   aluop           00 add, 01 sub (compare), 10 use funct bits
//   alusrca         00 PC, 01 OldPC, 10 rs1 data
//   alusrcb         00 rs2 data, 01 immediate, 10 constant 4
//   resultsrc       00 ALUOut reg, 01 memory data reg, 10 ALU result
//   adrsrc          memory address select: 0 PC, 1 Result
//   irwrite         load instruction register (and OldPC)
//   memwrite        memory write strobe
//   regwrite        register file write enable
//   pcwrite         PC load = pcupdate | (branch & zero)
//   illegal_op      sticky flag for an unknown opcode seen in DECODE
//   state           current state encoding (debug)
module multicycle_control #(
   parameter bit MEM_WAIT = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [1:0] aluop,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] resultsrc,
   output logic       adrsrc,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       pcwrite,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_BEQ      = 4'd8,
      S_JAL      = 4'd9
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   state_t cur_state;
   state_t nxt_state;
   logic   mem_rdy;      // mem_ready as seen by the FSM
   logic   pcupdate;
   logic   branch;
   logic   set_illegal;

   // With MEM_WAIT=0 the memory is assumed to complete in one cycle.
   assign mem_rdy = MEM_WAIT ? mem_ready : 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state  <= S_FETCH;
         illegal_op <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         if (set_illegal)
            illegal_op <= 1'b1;
      end
   end

   always_comb begin
      nxt_state   = S_FETCH;
      aluop       = 2'b00;
      alusrca     = 2'b00;
      alusrcb     = 2'b00;
      resultsrc   = 2'b00;
      adrsrc      = 1'b0;
      irwrite     = 1'b0;
      memwrite    = 1'b0;
      regwrite    = 1'b0;
      pcupdate    = 1'b0;
      branch      = 1'b0;
      set_illegal = 1'b0;
      case (cur_state)
         S_FETCH: begin
            // PC+4 goes straight to the PC through the combinational ALU result.
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            irwrite   = mem_rdy;
            pcupdate  = mem_rdy;
            nxt_state = mem_rdy ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // Precompute OldPC + imm into ALUOut for beq/jal.
            alusrca = 2'b01;
            alusrcb = 2'b01;
            case (opcode)
               OP_LW, OP_SW: nxt_state = S_MEMADR;
               OP_R:         nxt_state = S_EXECR;
               OP_BEQ:       nxt_state = S_BEQ;
               OP_JAL:       nxt_state = S_JAL;
               default: begin
                  nxt_state   = S_FETCH;
                  set_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca   = 2'b10;
            alusrcb   = 2'b01;
            nxt_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adrsrc    = 1'b1;
            nxt_state = mem_rdy ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            resultsrc = 2'b01;
            regwrite  = 1'b1;
         end
         S_MEMWRITE: begin
            adrsrc    = 1'b1;
            memwrite  = 1'b1;
            nxt_state = mem_rdy ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            alusrca   = 2'b10;
            aluop     = 2'b10;
            nxt_state = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite = 1'b1;
         end
         S_BEQ: begin
            alusrca = 2'b10;
            aluop   = 2'b01;
            branch  = 1'b1;
         end
         S_JAL: begin
            // ALU computes OldPC+4 for rd while ALUOut (target) loads the PC.
            alusrca   = 2'b01;
            alusrcb   = 2'b10;
            pcupdate  = 1'b1;
            nxt_state = S_ALUWB;
         end
         default: nxt_state = S_FETCH;
      endcase
   end

   assign pcwrite = pcupdate | (branch & zero);
   assign state   = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_ILL = 7'b1111111;

   // Output vector order:
   // aluop[12:11] alusrca[10:9] alusrcb[8:7] resultsrc[6:5] adrsrc irwrite memwrite regwrite pcwrite
   localparam logic [12:0] O_F1  = 13'b00_00_10_10_0_1_0_0_1;
   localparam logic [12:0] O_F0  = 13'b00_00_10_10_0_0_0_0_0;
   localparam logic [12:0] O_DEC = 13'b00_01_01_00_0_0_0_0_0;
   localparam logic [12:0] O_MA  = 13'b00_10_01_00_0_0_0_0_0;
   localparam logic [12:0] O_MR  = 13'b00_00_00_00_1_0_0_0_0;
   localparam logic [12:0] O_MWB = 13'b00_00_00_01_0_0_0_1_0;
   localparam logic [12:0] O_MW  = 13'b00_00_00_00_1_0_1_0_0;
   localparam logic [12:0] O_EX  = 13'b10_10_00_00_0_0_0_0_0;
   localparam logic [12:0] O_AWB = 13'b00_00_00_00_0_0_0_1_0;
   localparam logic [12:0] O_BQ1 = 13'b01_10_00_00_0_0_0_0_1;
   localparam logic [12:0] O_BQ0 = 13'b01_10_00_00_0_0_0_0_0;
   localparam logic [12:0] O_JAL = 13'b00_01_10_00_0_0_0_0_1;

   typedef struct {
      logic [6:0]  op;
      logic        z;
      logic        mr;
      logic [3:0]  st;
      logic [12:0] out;
      logic        il;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic [1:0] aluop;
   logic [1:0] alusrca;
   logic [1:0] alusrcb;
   logic [1:0] resultsrc;
   logic       adrsrc;
   logic       irwrite;
   logic       memwrite;
   logic       regwrite;
   logic       pcwrite;
   logic       illegal_op;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   vec_t tbl[34];

   multicycle_control #(.MEM_WAIT(1'b1)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .aluop(aluop), .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc),
      .adrsrc(adrsrc), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
      .pcwrite(pcwrite), .illegal_op(illegal_op), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [12:0] outs();
      return {aluop, alusrca, alusrcb, resultsrc, adrsrc, irwrite, memwrite, regwrite, pcwrite};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive inputs at the falling edge, sample 1ns later (well clear of the rising edge).
   task automatic step(input logic [6:0] op, input logic z, input logic mr);
      @(negedge clk);
      opcode    = op;
      zero      = z;
      mem_ready = mr;
      #1;
   endtask

   initial begin
      tbl[0]  = '{OP_R,   1'b0, 1'b1, 4'd0, O_F1,  1'b0};
      tbl[1]  = '{OP_R,   1'b0, 1'b1, 4'd1, O_DEC, 1'b0};
      tbl[2]  = '{OP_R,   1'b0, 1'b1, 4'd6, O_EX,  1'b0};
      tbl[3]  = '{OP_R,   1'b0, 1'b1, 4'd7, O_AWB, 1'b0};
      tbl[4]  = '{OP_LW,  1'b0, 1'b1, 4'd0, O_F1,  1'b0};
      tbl[5]  = '{OP_LW,  1'b0, 1'b1, 4'd1, O_DEC, 1'b0};
      tbl[6]  = '{OP_LW,  1'b0, 1'b1, 4'd2, O_MA,  1'b0};
      tbl[7]  = '{OP_LW,  1'b0, 1'b0, 4'd3, O_MR,  1'b0};
      tbl[8]  = '{OP_LW,  1'b0, 1'b0, 4'd3, O_MR,  1'b0};
      tbl[9]  = '{OP_LW,  1'b0, 1'b1, 4'd3, O_MR,  1'b0};
      tbl[10] = '{OP_LW,  1'b0, 1'b1, 4'd4, O_MWB, 1'b0};
      tbl[11] = '{OP_SW,  1'b0, 1'b1, 4'd0, O_F1,  1'b0};
      tbl[12] = '{OP_SW,  1'b0, 1'b1, 4'd1, O_DEC, 1'b0};
      tbl[13] = '{OP_SW,  1'b0, 1'b1, 4'd2, O_MA,  1'b0};
      tbl[14] = '{OP_SW,  1'b0, 1'b0, 4'd5, O_MW,  1'b0};
      tbl[15] = '{OP_SW,  1'b0, 1'b1, 4'd5, O_MW,  1'b0};
      tbl[16] = '{OP_BEQ, 1'b0, 1'b0, 4'd0, O_F0,  1'b0};
      tbl[17] = '{OP_BEQ, 1'b1, 1'b1, 4'd0, O_F1,  1'b0};
      tbl[18] = '{OP_BEQ, 1'b1, 1'b1, 4'd1, O_DEC, 1'b0};
      tbl[19] = '{OP_BEQ, 1'b1, 1'b1, 4'd8, O_BQ1, 1'b0};
      tbl[20] = '{OP_BEQ, 1'b0, 1'b1, 4'd0, O_F1,  1'b0};
      tbl[21] = '{OP_BEQ, 1'b0, 1'b1, 4'd1, O_DEC, 1'b0};
      tbl[22] = '{OP_BEQ, 1'b0, 1'b1, 4'd8, O_BQ0, 1'b0};
      tbl[23] = '{OP_JAL, 1'b0, 1'b1, 4'd0, O_F1,  1'b0};
      tbl[24] = '{OP_JAL, 1'b0, 1'b1, 4'd1, O_DEC, 1'b0};
      tbl[25] = '{OP_JAL, 1'b0, 1'b1, 4'd9, O_JAL, 1'b0};
      tbl[26] = '{OP_JAL, 1'b0, 1'b1, 4'd7, O_AWB, 1'b0};
      tbl[27] = '{OP_ILL, 1'b0, 1'b1, 4'd0, O_F1,  1'b0};
      tbl[28] = '{OP_ILL, 1'b0, 1'b1, 4'd1, O_DEC, 1'b0};
      tbl[29] = '{OP_R,   1'b0, 1'b1, 4'd0, O_F1,  1'b1};
      tbl[30] = '{OP_R,   1'b0, 1'b1, 4'd1, O_DEC, 1'b1};
      tbl[31] = '{OP_R,   1'b0, 1'b1, 4'd6, O_EX,  1'b1};
      tbl[32] = '{OP_R,   1'b0, 1'b1, 4'd7, O_AWB, 1'b1};
      tbl[33] = '{OP_SW,  1'b0, 1'b1, 4'd0, O_F1,  1'b1};

      // Reset state, with mem_ready gating visible during reset.
      rst       = 1'b1;
      opcode    = OP_R;
      zero      = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_state", {12'd0, state}, 16'd0);
      check("reset_outs_mr0", {3'd0, outs()}, {3'd0, O_F0});
      check("reset_illegal", {15'd0, illegal_op}, 16'd0);
      mem_ready = 1'b1;
      #1;
      check("reset_outs_mr1", {3'd0, outs()}, {3'd0, O_F1});
      @(negedge clk);
      rst = 1'b0;

      // Table walk: each row is sampled in the cycle it describes.
      for (int i = 0; i < 34; i++) begin
         if (i != 0) @(negedge clk);
         opcode    = tbl[i].op;
         zero      = tbl[i].z;
         mem_ready = tbl[i].mr;
         #1;
         check($sformatf("row%0d_state", i), {12'd0, state}, {12'd0, tbl[i].st});
         check($sformatf("row%0d_outs", i), {3'd0, outs()}, {3'd0, tbl[i].out});
         check($sformatf("row%0d_illegal", i), {15'd0, illegal_op}, {15'd0, tbl[i].il});
      end

      // Reset pulse in the middle of a stalled store.
      step(OP_SW, 1'b0, 1'b1);
      check("sw2_decode", {12'd0, state}, 16'd1);
      step(OP_SW, 1'b0, 1'b1);
      check("sw2_memadr", {12'd0, state}, 16'd2);
      step(OP_SW, 1'b0, 1'b0);
      check("sw2_memwrite_state", {12'd0, state}, 16'd5);
      check("sw2_memwrite_strobe", {15'd0, memwrite}, 16'd1);
      check("sw2_illegal_sticky", {15'd0, illegal_op}, 16'd1);
      #2 rst = 1'b1;
      #1;
      check("midrst_state", {12'd0, state}, 16'd0);
      check("midrst_memwrite", {15'd0, memwrite}, 16'd0);
      check("midrst_regwrite", {15'd0, regwrite}, 16'd0);
      check("midrst_illegal", {15'd0, illegal_op}, 16'd0);
      check("midrst_irwrite", {15'd0, irwrite}, 16'd0);
      @(negedge clk);
      rst       = 1'b0;
      mem_ready = 1'b1;
      #1;
      check("post_rst_fetch", {12'd0, state}, 16'd0);
      check("post_rst_outs", {3'd0, outs()}, {3'd0, O_F1});
      step(OP_R, 1'b0, 1'b1);
      check("post_rst_decode", {12'd0, state}, 16'd1);
      check("post_rst_illegal", {15'd0, illegal_op}, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
